jacobi_iter_ctrl: RTL
=====================

Name: jacobi_iter_ctrl

Overview:
- Parametrised iteration sequencer for the Jacobi solver datapath, placed after the divider.
- Accepts one updated V value per row together with that row's previous-iteration value. Writes the new value into a BANKS-way, ping-pong-sectioned V SRAM.
- Tracks the maximum per-row change in each iteration and decides whether to end the run (converged, or iteration limit reached) or to start the next iteration.
- Generalises the current vSRAMwrite and iter_done_calc pair: bank count, data width and row count are parametrised, and it adds convergence detection and an iteration limit.

Parameters:
DATA_W, 48, width of V values and tolerance (signed two's complement)
ROW_W, 10, row index width
BANKS, 4, number of V SRAM banks; must be a power of 2, at least 2
BANK_AW, 9, per-bank address width; the MSB is the section bit
ITER_W, 8, iteration counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse that begins a solve; honoured only when busy=0
n_rows  in  ROW_W  matrix dimension; sampled at start
max_iter  in  ITER_W  iteration limit, 0 = unlimited; sampled at start
tol  in  DATA_W  unsigned convergence threshold; sampled at start
in_valid  in  1  new V value present
in_ready  out  1  high only in RUN
in_row  in  ROW_W  row index of the value
in_new  in  DATA_W  newly computed V[row]
in_old  in  DATA_W  previous-iteration V[row]
wr_en  out  BANKS  one-hot bank write enable
wr_addr  out  BANK_AW  {vsram_section, row>>log2(BANKS)}
wr_data  out  DATA_W  registered in_new
vsram_section  out  1  section currently being written; upstream reads the other section
iter_start  out  1  1-cycle pulse at the start of each iteration
iter_done  out  1  1-cycle pulse at the end of each iteration
busy  out  1  state is RUN or CHECK
done  out  1  high in DONE
converged  out  1  valid when done=1
iter_count  out  ITER_W  number of completed iterations
max_delta  out  DATA_W+1  running maximum of |in_new-in_old| within the current iteration
err_row  out  1  sticky flag: an out-of-range row was presented

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs are 0 and all internal counters are cleared.
- States: IDLE, RUN, CHECK, DONE.
- IDLE + start:
  - Latch n_rows, max_iter and tol. Clear iter_count, rows_seen and max_delta. Set vsram_section=0.
  - If n_rows=0: go to DONE with converged=1. Otherwise go to RUN and pulse iter_start in the next cycle.
- Handshake: a value is accepted when in_valid && in_ready.
  - in_valid is ignored outside RUN.
  - in_row >= n_rows: the value is accepted but dropped (no write, no delta update, not counted), and err_row is set.
- Accepted value at cycle t:
  - At t+1: wr_en[in_row mod BANKS]=1, with wr_addr and wr_data registered. wr_en is 0 in all other cycles.
  - delta = |in_new - in_old|, computed in DATA_W+1 bits so the most negative difference does not overflow.
  - max_delta = max(max_delta, delta), visible at t+1. rows_seen increments.
- Duplicate rows are not detected; each accepted value counts as one row.
- When rows_seen reaches n_rows (last accepted value at cycle t): state is CHECK at t+1 and in_ready=0.
- CHECK (one cycle, t+1), with results registered and visible at t+2:
  - iter_count increments and saturates at all-ones. iter_done pulses.
  - If max_delta <= {0,tol}: converged=1, go to DONE.
  - Else if max_iter!=0 and the new iter_count==max_iter: converged=0, go to DONE.
  - Else: toggle vsram_section, clear max_delta and rows_seen, go to RUN, pulse iter_start. in_ready is high again at t+2.
- DONE: done=1. converged, iter_count and vsram_section hold. max_delta holds the final iteration's value.
- start in DONE: behaves as start in IDLE and clears err_row. start while busy is ignored.
- Reset mid-operation: immediate return to IDLE. Writes that are in flight are lost, and wr_en drops asynchronously.

Optional Feature:
- Macro ITER_ABORT_EN adds input abort (1 bit).
- With the macro: abort=1 in RUN or CHECK returns to IDLE on the next edge. No iter_done pulse is issued. The pending write registered that cycle still completes. done=0, converged=0, and iter_count holds.
- Without the macro: no abort port exists, and only reset exits a solve.

Test Plan:
1. reset=0 during traffic -> all outputs 0 immediately; after release, state is IDLE and in_ready=0.
2. BANKS=4, n_rows=8, tol=0x10; rows 0..7 sent with |new-old|=0x5 -> wr_en one-hot at 1,2,4,8,1,2,4,8 with wr_addr 0,0,0,0,1,1,1,1; iter_done pulses; converged=1, iter_count=1, vsram_section=0.
3. n_rows=4, max_iter=3, every delta=0x100, tol=0x10 -> three iter_start pulses; section sequence 0,1,0; done with converged=0, iter_count=3.
4. in_new=0x800000000000, in_old=0x7FFFFFFFFFFF -> max_delta=0x0FFFFFFFFFFFF (49-bit), no overflow.
5. in_row=9 with n_rows=8 -> no wr_en, err_row=1, rows_seen unchanged; start is ignored while busy; n_rows=0 -> done=1, converged=1, iter_count=0.
6. ITER_ABORT_EN defined, abort mid-RUN -> IDLE next cycle, no iter_done pulse, iter_count unchanged.

Source files
------------

// File: rtl/jacobi_iter_ctrl_if.sv
// ---------------------------------------------------------------------------
// jacobi_iter_ctrl_if
// Value stream from the divider into the iteration controller, plus the
// V SRAM write port that the controller drives.
//
// Handshake: a value transfers on a rising clock edge where in_valid and
// in_ready are both high. The source holds in_row/in_new/in_old stable while
// in_valid is high and in_ready is low. in_ready does not depend on in_valid.
//
// Signals:
//   in_valid, in_row, in_new, in_old : value from upstream (master -> slave)
//   in_ready                         : controller can accept (slave -> master)
//   wr_en, wr_addr, wr_data          : V SRAM write port (slave -> master)
// ---------------------------------------------------------------------------
interface jacobi_iter_ctrl_if #(
  parameter int DATA_W  = 48,
  parameter int ROW_W   = 10,
  parameter int BANKS   = 4,
  parameter int BANK_AW = 9
);
  logic               in_valid;
  logic               in_ready;
  logic [ROW_W-1:0]   in_row;
  logic [DATA_W-1:0]  in_new;
  logic [DATA_W-1:0]  in_old;
  logic [BANKS-1:0]   wr_en;
  logic [BANK_AW-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;

  modport master (
    output in_valid, in_row, in_new, in_old,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_row, in_new, in_old,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/jacobi_iter_ctrl.sv
// ---------------------------------------------------------------------------
// jacobi_iter_ctrl
// Iteration sequencer for the Jacobi solver. It takes one updated V value per
// row and writes it into a BANKS-way, ping-pong-sectioned V SRAM. It also
// tracks the largest per-row change in each iteration and then either ends
// the solve (converged, or iteration limit reached) or starts the next
// iteration in the other SRAM section.
//
// Optional feature: define ITER_ABORT_EN to add the 'abort' input. When abort
// is high in RUN or CHECK, the solve returns to IDLE on the next edge.
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   start          : solve request, honoured in IDLE or DONE
//   n_rows, max_iter, tol : solve setup, sampled at start (max_iter 0 = no limit)
//   abort          : (ITER_ABORT_EN only) cancel the running solve
//   bus            : value stream in, V SRAM write port out
//   vsram_section  : section being written; upstream reads the other section
//   iter_start/iter_done : 1-cycle pulses at the start and end of each iteration
//   busy, done, converged, iter_count, max_delta, err_row : status
//   state_dbg      : FSM state (0 IDLE, 1 RUN, 2 CHECK, 3 DONE)
// ---------------------------------------------------------------------------
module jacobi_iter_ctrl #(
  parameter int DATA_W  = 48,
  parameter int ROW_W   = 10,
  parameter int BANKS   = 4,
  parameter int BANK_AW = 9,
  parameter int ITER_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  n_rows,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [DATA_W-1:0] tol,
`ifdef ITER_ABORT_EN
  input  logic              abort,
`endif
  jacobi_iter_ctrl_if.slave bus,
  output logic              vsram_section,
  output logic              iter_start,
  output logic              iter_done,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic [DATA_W:0]   max_delta,
  output logic              err_row,
  output logic [1:0]        state_dbg
);

  localparam int LOG2B = $clog2(BANKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  n_rows_q;
  logic [ROW_W-1:0]  rows_seen;
  logic [ITER_W-1:0] max_iter_q;
  logic [DATA_W-1:0] tol_q;

  logic              abort_req;
  logic              accept;
  logic              row_ok;
  logic              last_row;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   delta;
  logic [ITER_W-1:0] iter_next;

`ifdef ITER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign bus.in_ready = (state == RUN);
  assign busy         = (state == RUN) || (state == CHECK);
  assign done         = (state == DONE);
  assign state_dbg    = state;

  assign accept = bus.in_valid && (state == RUN);
  assign row_ok = (bus.in_row < n_rows_q);

  // One extra bit so that the most negative minus the most positive value
  // still fits; the magnitude is then always representable.
  assign diff  = {bus.in_new[DATA_W-1], bus.in_new} - {bus.in_old[DATA_W-1], bus.in_old};
  assign delta = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;

  assign last_row  = (({1'b0, rows_seen} + (ROW_W+1)'(1)) == {1'b0, n_rows_q});
  assign iter_next = (iter_count == {ITER_W{1'b1}}) ? iter_count : iter_count + ITER_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      n_rows_q      <= '0;
      rows_seen     <= '0;
      max_iter_q    <= '0;
      tol_q         <= '0;
      bus.wr_en     <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      vsram_section <= 1'b0;
      iter_start    <= 1'b0;
      iter_done     <= 1'b0;
      converged     <= 1'b0;
      iter_count    <= '0;
      max_delta     <= '0;
      err_row       <= 1'b0;
    end else begin
      bus.wr_en  <= '0;
      iter_start <= 1'b0;
      iter_done  <= 1'b0;

      // Datapath for an accepted value. It is independent of abort, so a
      // write accepted in the abort cycle still reaches the SRAM.
      if (accept) begin
        if (row_ok) begin
          bus.wr_en   <= {{(BANKS-1){1'b0}}, 1'b1} << bus.in_row[LOG2B-1:0];
          bus.wr_addr <= {vsram_section, (BANK_AW-1)'(bus.in_row >> LOG2B)};
          bus.wr_data <= bus.in_new;
          rows_seen   <= rows_seen + ROW_W'(1);
          if (delta > max_delta) max_delta <= delta;
        end else begin
          err_row <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_rows_q      <= n_rows;
            max_iter_q    <= max_iter;
            tol_q         <= tol;
            iter_count    <= '0;
            rows_seen     <= '0;
            max_delta     <= '0;
            vsram_section <= 1'b0;
            if (state == DONE) err_row <= 1'b0;
            if (n_rows == '0) begin
              converged <= 1'b1;
              state     <= DONE;
            end else begin
              converged  <= 1'b0;
              iter_start <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_req) begin
            converged <= 1'b0;
            state     <= IDLE;
          end else if (accept && row_ok && last_row) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (abort_req) begin
            converged <= 1'b0;
            state     <= IDLE;
          end else begin
            iter_count <= iter_next;
            iter_done  <= 1'b1;
            if (max_delta <= {1'b0, tol_q}) begin
              converged <= 1'b1;
              state     <= DONE;
            end else if ((max_iter_q != '0) && (iter_next == max_iter_q)) begin
              converged <= 1'b0;
              state     <= DONE;
            end else begin
              // Next iteration writes the other section while upstream
              // reads the one just completed.
              vsram_section <= ~vsram_section;
              max_delta     <= '0;
              rows_seen     <= '0;
              iter_start    <= 1'b1;
              state         <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
